// File: rtl/btn_pkg.sv
// Shared constants for the button/LED conditioning slice.
// Holds the FSM state encodings and the default 1 kHz tick divisor.
package btn_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int FCNT_1KHZ = 100_000;

endpackage

// File: rtl/ms_tick_gen.sv
// Restartable prescaler: one-cycle tick every FCNT clocks, counted from the last clr.
// The count restarts at zero on clr, so the first tick comes FCNT cycles after clr drops.
module ms_tick_gen
  import btn_pkg::*;
#(
  parameter int FCNT = FCNT_1KHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int PW = $clog2(FCNT);
  localparam logic [PW-1:0] PRE_LAST = PW'(FCNT - 1);

  logic [PW-1:0] pre_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
    end else if (clr || pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  assign tick = (pre_cnt == PRE_LAST);

endmodule

// File: rtl/pulse_stretch_driver.sv
// Stretches single-cycle event strobes into fixed ON/GAP blinks for an LED or buzzer.
// Events that arrive during a blink are queued in a saturating counter and replayed in order.
module pulse_stretch_driver
  import btn_pkg::*;
#(
  parameter int FCNT   = FCNT_1KHZ,
  parameter int ON_MS  = 50,
  parameter int GAP_MS = 50,
  parameter int QW     = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_pulse,
  output logic          o_level,
  output logic          o_busy,
  output logic [QW-1:0] o_pending,
  output logic          o_overflow
);

  localparam int MAX_MS = (ON_MS > GAP_MS) ? ON_MS : GAP_MS;
  localparam int MW     = $clog2(MAX_MS + 1);
  localparam logic [MW-1:0] ON_LAST  = MW'(ON_MS - 1);
  localparam logic [MW-1:0] GAP_LAST = MW'(GAP_MS - 1);
  localparam logic [QW-1:0] PEND_MAX = '1;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [MW-1:0] ms_cnt;
  logic          tick;
  logic          clr;
  logic          on_last;
  logic          gap_last;
  logic [QW-1:0] pending_nxt;
  logic          overflow_nxt;

  // Timing restarts on every state change so ON and GAP lengths are exact, not tick-aligned.
  assign clr = (state_nxt != state) || (state == ST_IDLE);

  ms_tick_gen #(.FCNT(FCNT)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  assign on_last  = (state == ST_ON)  && tick && (ms_cnt == ON_LAST);
  assign gap_last = (state == ST_GAP) && tick && (ms_cnt == GAP_LAST);
  assign o_busy   = (state != ST_IDLE);

  always_comb begin
    state_nxt    = state;
    pending_nxt  = o_pending;
    overflow_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_pulse) state_nxt = ST_ON;
      end
      ST_ON, ST_GAP: begin
        if (gap_last && o_pending != '0) begin
          // A simultaneous new event replaces the one being consumed.
          state_nxt = ST_ON;
          if (!i_pulse) pending_nxt = o_pending - QW'(1);
        end else if (gap_last) begin
          state_nxt = i_pulse ? ST_ON : ST_IDLE;
        end else begin
          if (on_last) state_nxt = ST_GAP;
          if (i_pulse) begin
            if (o_pending == PEND_MAX) overflow_nxt = 1'b1;
            else pending_nxt = o_pending + QW'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      ms_cnt     <= '0;
      o_pending  <= '0;
      o_level    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state      <= state_nxt;
      o_pending  <= pending_nxt;
      o_level    <= (state_nxt == ST_ON);
      o_overflow <= overflow_nxt;
      if (clr) ms_cnt <= '0;
      else if (tick) ms_cnt <= ms_cnt + MW'(1);
    end
  end

endmodule

// File: tb/tb_pulse_stretch_driver.sv
// Self-checking bench for pulse_stretch_driver with small timing parameters.
// A countdown-based reference model tracks the remaining blink time and the queued event count.
module tb_pulse_stretch_driver;

  localparam int FCNT    = 4;
  localparam int ON_MS   = 3;
  localparam int GAP_MS  = 2;
  localparam int QW      = 2;
  localparam int ON_CYC  = ON_MS * FCNT;
  localparam int GAP_CYC = GAP_MS * FCNT;
  localparam int TOTAL   = ON_CYC + GAP_CYC;
  localparam int PMAX    = (1 << QW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_pulse = 1'b0;
  logic          o_level;
  logic          o_busy;
  logic [QW-1:0] o_pending;
  logic          o_overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: cycles left in the current blink (0 = idle), queued events, overflow strobe.
  int m_rem = 0;
  int m_pend = 0;
  int m_ovf = 0;

  pulse_stretch_driver #(
    .FCNT(FCNT), .ON_MS(ON_MS), .GAP_MS(GAP_MS), .QW(QW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_pulse    (i_pulse),
    .o_level    (o_level),
    .o_busy     (o_busy),
    .o_pending  (o_pending),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%0d expected=%0d", tag, cyc, actual, expected);
    end
  endtask

  task automatic modelStep(input logic p);
    m_ovf = 0;
    if (m_rem == 0) begin
      if (p) m_rem = TOTAL;
    end else if (m_rem == 1) begin
      if (m_pend > 0) begin
        m_rem = TOTAL;
        if (!p) m_pend--;
      end else if (p) begin
        m_rem = TOTAL;
      end else begin
        m_rem = 0;
      end
    end else begin
      m_rem--;
      if (p) begin
        if (m_pend == PMAX) m_ovf = 1;
        else m_pend++;
      end
    end
  endtask

  task automatic checkModel();
    checkOutput("level", o_level, (m_rem > GAP_CYC));
    checkOutput("busy", o_busy, (m_rem != 0));
    checkOutput("pending", o_pending, m_pend);
    checkOutput("overflow", o_overflow, m_ovf);
  endtask

  // Called just after a falling edge; drives one cycle and checks the following cycle.
  task automatic applyStimulus(input logic p);
    i_pulse = p;
    @(posedge clk);
    modelStep(p);
    @(negedge clk);
    cyc++;
    checkModel();
  endtask

  task automatic applyReset();
    #2;
    rst = 1'b0;
    i_pulse = 1'b0;
    m_rem = 0;
    m_pend = 0;
    m_ovf = 0;
    #1;
    checkOutput("rst_level", o_level, 0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_pending", o_pending, 0);
    checkOutput("rst_overflow", o_overflow, 0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    checkModel();
  endtask

  task automatic drain();
    for (int i = 0; i < 70; i++) applyStimulus(1'b0);
  endtask

  initial begin
    logic [127:0] pat;
    int rises;
    int ovf_cnt;
    int hi_cnt;
    int thresh;
    logic prev_level;

    #1;
    checkOutput("init_level", o_level, 0);
    checkOutput("init_busy", o_busy, 0);
    checkOutput("init_pending", o_pending, 0);
    checkOutput("init_overflow", o_overflow, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    checkModel();

    // Single pulse: 12 cycles high, busy through the gap.
    cyc = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(i == 0);
      checkOutput("s1_level", o_level, (cyc <= ON_CYC));
      checkOutput("s1_busy", o_busy, (cyc <= TOTAL));
    end
    drain();

    // Two queued events replayed back to back.
    pat = '0;
    pat[0] = 1'b1; pat[3] = 1'b1; pat[5] = 1'b1;
    cyc = 0;
    for (int i = 0; i < 70; i++) begin
      applyStimulus(pat[i]);
      if (cyc == 6)  checkOutput("s2_pending", o_pending, 2);
      if (cyc == 20 || cyc == 40) checkOutput("s2_gap_end", o_level, 0);
      if (cyc == 21 || cyc == 41) checkOutput("s2_blink_start", o_level, 1);
      if (cyc == 61) checkOutput("s2_idle", o_busy, 0);
    end
    drain();

    // Saturation: the fifth event is dropped with a single overflow strobe.
    pat = '0;
    pat[0] = 1'b1; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b1; pat[5] = 1'b1;
    cyc = 0;
    rises = 0;
    ovf_cnt = 0;
    prev_level = 1'b0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(pat[i]);
      if (o_level && !prev_level) rises++;
      prev_level = o_level;
      if (o_overflow) ovf_cnt++;
      if (cyc == 6) checkOutput("s3_overflow_strobe", o_overflow, 1);
      if (cyc == 5) checkOutput("s3_pending_sat", o_pending, PMAX);
    end
    checkOutput("s3_blinks", rises, 4);
    checkOutput("s3_overflows", ovf_cnt, 1);
    drain();

    // Pulse on the last gap cycle restarts ON with no idle cycle.
    pat = '0;
    pat[0] = 1'b1; pat[20] = 1'b1;
    cyc = 0;
    for (int i = 0; i < 45; i++) begin
      applyStimulus(pat[i]);
      if (cyc <= 2 * TOTAL) checkOutput("s4_busy", o_busy, 1);
      if (cyc == 21) checkOutput("s4_level", o_level, 1);
    end
    drain();

    pat = '0;
    pat[0] = 1'b1; pat[5] = 1'b1; pat[20] = 1'b1;
    cyc = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(pat[i]);
      if (cyc == 21) checkOutput("s4b_pending", o_pending, 1);
    end
    drain();

    // Asynchronous reset mid-blink, then a clean blink afterwards.
    cyc = 0;
    for (int i = 0; i < 6; i++) applyStimulus(i == 0 || i == 2);
    applyReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0);
      checkOutput("s5_quiet", o_level, 0);
    end
    hi_cnt = 0;
    applyStimulus(1'b1);
    if (o_level) hi_cnt++;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b0);
      if (o_level) hi_cnt++;
    end
    checkOutput("s5_blink_len", hi_cnt, ON_CYC);
    drain();

    // Random traffic at varying densities with occasional resets.
    thresh = 10;
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) thresh = $urandom_range(0, 40);
      if ($urandom_range(0, 599) == 0) applyReset();
      else applyStimulus($urandom_range(0, 99) < thresh);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
